logmag_pixel: RTL and testbench

- Converts complex FFT output bins into 8-bit log-magnitude pixel indices.
- Sits directly upstream of the false-colour map stage; its o_pixel feeds that stage's 8-bit pixel input.
- Four-stage pipeline with valid/ready flow control, frame-end (last) pass-through, and a frame-length check.

---
 rtl/logmag_pixel_if.sv | 26 ++
 rtl/logmag_pixel.sv | 112 +++++++++++
 tb/tb_logmag_pixel.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logmag_pixel_if.sv
// Stream bundle for the log-magnitude stage: complex bins in, 8-bit pixel codes out.
// The slave modport is the block's view; the master modport is the producer/consumer side.
interface logmag_pixel_if #(
  parameter int IW = 16
);
  logic                 i_valid;
  logic                 o_ready;
  logic signed [IW-1:0] i_real;
  logic signed [IW-1:0] i_imag;
  logic                 i_last;
  logic                 o_valid;
  logic                 i_ready;
  logic [7:0]           o_pixel;
  logic                 o_last;
  logic                 o_frame_err;

  modport slave (
    input  i_valid, i_real, i_imag, i_last, i_ready,
    output o_ready, o_valid, o_pixel, o_last, o_frame_err
  );

  modport master (
    output i_valid, i_real, i_imag, i_last, i_ready,
    input  o_ready, o_valid, o_pixel, o_last, o_frame_err
  );
endinterface

// File: rtl/logmag_pixel.sv
// Complex FFT bin -> 8-bit log-magnitude pixel: square, sum, leading-one log, offset/gain clip.
// Four lockstep stages advance on a single enable; a bin counter checks frame length at input.
module logmag_pixel #(
  parameter int IW     = 16,
  parameter int OFFSET = 0,
  parameter int LGGAIN = 0,
  parameter int LGFFT  = 10
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  logmag_pixel_if.slave s
);
  localparam int              MW       = 2 * IW;
  localparam logic [7:0]      OFS      = 8'(OFFSET);
  localparam logic [LGFFT-1:0] LAST_BIN = '1;

  logic                  w_ce;
  logic                  w_accept;
  logic signed [IW-1:0]  w_re;
  logic signed [IW-1:0]  w_im;
  logic signed [MW-1:0]  w_re_sq;
  logic signed [MW-1:0]  w_im_sq;
  logic [4:0]            w_e;
  logic [2:0]            w_frac;
  logic [7:0]            w_lcode;
  logic [7:0]            w_diff;
  logic [10:0]           w_shift;
  logic [7:0]            w_pixel;
  logic                  w_bin_full;
  logic                  w_len_err;

  logic [3:0]            r_vld;
  logic [3:0]            r_lst;
  logic [MW-1:0]         r_re_sq;
  logic [MW-1:0]         r_im_sq;
  logic [MW-1:0]         r_mag2;
  logic [7:0]            r_lcode;
  logic [7:0]            r_pixel;
  logic [LGFFT-1:0]      r_bin;
  logic                  r_frame_err;

  // Whole pipe stalls only when the output register is full and not being taken.
  assign w_ce     = !r_vld[3] || s.i_ready;
  assign w_accept = s.i_valid && w_ce;

  assign w_re    = s.i_real;
  assign w_im    = s.i_imag;
  assign w_re_sq = w_re * w_re;
  assign w_im_sq = w_im * w_im;

  // Exponent is the top set bit; the mantissa is the next three bits, left-aligned when e < 3.
  always_comb begin
    w_e = 5'd0;
    for (int i = 0; i < MW; i++) begin
      if (r_mag2[i]) begin
        w_e = 5'(i);
      end
    end
    if (w_e >= 5'd3) begin
      w_frac = 3'(r_mag2 >> (w_e - 5'd3));
    end else begin
      w_frac = 3'(r_mag2 << (5'd3 - w_e));
    end
    w_lcode = (r_mag2 == '0) ? 8'd0 : {w_e, w_frac};
  end

  assign w_diff  = (r_lcode > OFS) ? (r_lcode - OFS) : 8'd0;
  assign w_shift = {3'b000, w_diff} << LGGAIN;
  assign w_pixel = (|w_shift[10:8]) ? 8'hFF : w_shift[7:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_vld   <= '0;
      r_lst   <= '0;
      r_re_sq <= '0;
      r_im_sq <= '0;
      r_mag2  <= '0;
      r_lcode <= '0;
      r_pixel <= '0;
    end else if (w_ce) begin
      r_vld   <= {r_vld[2:0], s.i_valid};
      r_lst   <= {r_lst[2:0], s.i_valid && s.i_last};
      r_re_sq <= $unsigned(w_re_sq);
      r_im_sq <= $unsigned(w_im_sq);
      r_mag2  <= r_re_sq + r_im_sq;
      r_lcode <= w_lcode;
      r_pixel <= w_pixel;
    end
  end

  // Length error: a last that arrives early, or a full frame that arrives without last.
  assign w_bin_full = (r_bin == LAST_BIN);
  assign w_len_err  = s.i_last ? !w_bin_full : w_bin_full;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bin       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_accept && w_len_err;
      if (w_accept) begin
        r_bin <= s.i_last ? '0 : r_bin + 1'b1;
      end
    end
  end

  assign s.o_ready     = w_ce;
  assign s.o_valid     = r_vld[3];
  assign s.o_last      = r_lst[3];
  assign s.o_pixel     = r_pixel;
  assign s.o_frame_err = r_frame_err;
endmodule

// File: tb/tb_logmag_pixel.sv
// Drives three parameterisations of logmag_pixel from one stimulus stream and
// scores each against its own queue of expected {last, pixel} values.
module tb_logmag_pixel;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               i_valid = 1'b0;
  logic               i_last  = 1'b0;
  logic               i_ready = 1'b1;
  logic signed [15:0] i_real  = '0;
  logic signed [15:0] i_imag  = '0;

  logmag_pixel_if #(.IW(16)) ifa ();
  logmag_pixel_if #(.IW(16)) ifb ();
  logmag_pixel_if #(.IW(16)) ifc ();

  assign ifa.i_valid = i_valid;
  assign ifa.i_last  = i_last;
  assign ifa.i_ready = i_ready;
  assign ifa.i_real  = i_real;
  assign ifa.i_imag  = i_imag;
  assign ifb.i_valid = i_valid;
  assign ifb.i_last  = i_last;
  assign ifb.i_ready = i_ready;
  assign ifb.i_real  = i_real;
  assign ifb.i_imag  = i_imag;
  assign ifc.i_valid = i_valid;
  assign ifc.i_last  = i_last;
  assign ifc.i_ready = i_ready;
  assign ifc.i_real  = i_real;
  assign ifc.i_imag  = i_imag;

  logmag_pixel #(.IW(16), .OFFSET(0), .LGGAIN(0), .LGFFT(10)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .s(ifa));
  logmag_pixel #(.IW(16), .OFFSET(64), .LGGAIN(1), .LGFFT(10)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .s(ifb));
  logmag_pixel #(.IW(16), .OFFSET(0), .LGGAIN(0), .LGFFT(3)) dut_c (
    .i_clk(clk), .i_reset_n(rst_n), .s(ifc));

  int n_pass  = 0;
  int n_total = 0;
  int cnt_c   = 0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic [8:0] qc[$];

  function automatic logic [7:0] model_pix(input int re, input int im, input int ofs, input int gain);
    longint m;
    int e, f, p;
    m = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    e = -1;
    for (int i = 0; i < 40; i++) if (((m >> i) & 64'd1) != 0) e = i;
    if (e < 0) return 8'd0;
    if (e >= 3) f = int'((m >> (e - 3)) & 64'd7);
    else        f = int'((m << (3 - e)) & 64'd7);
    p = 8 * e + f - ofs;
    if (p < 0) p = 0;
    p = p << gain;
    if (p > 255) p = 255;
    return 8'(p);
  endfunction

  task automatic push_sample(input int re, input int im, input logic last, output logic err_c);
    qa.push_back({last, model_pix(re, im, 0, 0)});
    qb.push_back({last, model_pix(re, im, 64, 1)});
    qc.push_back({last, model_pix(re, im, 0, 0)});
    err_c = (last && cnt_c != 7) || (!last && cnt_c == 7);
    cnt_c = last ? 0 : (cnt_c + 1) % 8;
  endtask

  // Output scoreboard: every handshake on any instance pops and compares.
  always @(negedge clk) begin
    logic [8:0] exp;
    if (ifa.o_valid && i_ready) begin
      n_total++;
      if (qa.size() == 0) $display("FAIL sb_a unexpected output got=%0d exp=none", ifa.o_pixel);
      else begin
        exp = qa.pop_front();
        if ({ifa.o_last, ifa.o_pixel} !== exp)
          $display("FAIL sb_a got pixel=%0d last=%0b exp pixel=%0d last=%0b", ifa.o_pixel, ifa.o_last, exp[7:0], exp[8]);
        else n_pass++;
      end
      $display("out a: pixel=%0d last=%0b", ifa.o_pixel, ifa.o_last);
    end
    if (ifb.o_valid && i_ready) begin
      n_total++;
      if (qb.size() == 0) $display("FAIL sb_b unexpected output got=%0d exp=none", ifb.o_pixel);
      else begin
        exp = qb.pop_front();
        if ({ifb.o_last, ifb.o_pixel} !== exp)
          $display("FAIL sb_b got pixel=%0d last=%0b exp pixel=%0d last=%0b", ifb.o_pixel, ifb.o_last, exp[7:0], exp[8]);
        else n_pass++;
      end
    end
    if (ifc.o_valid && i_ready) begin
      n_total++;
      if (qc.size() == 0) $display("FAIL sb_c unexpected output got=%0d exp=none", ifc.o_pixel);
      else begin
        exp = qc.pop_front();
        if ({ifc.o_last, ifc.o_pixel} !== exp)
          $display("FAIL sb_c got pixel=%0d last=%0b exp pixel=%0d last=%0b", ifc.o_pixel, ifc.o_last, exp[7:0], exp[8]);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++; if (ifa.o_valid !== 1'b0) $display("FAIL reset_o_valid got=%0b exp=0", ifa.o_valid); else n_pass++;
    n_total++; if (ifa.o_pixel !== 8'd0) $display("FAIL reset_o_pixel got=%0d exp=0", ifa.o_pixel); else n_pass++;
    n_total++; if (ifa.o_last !== 1'b0) $display("FAIL reset_o_last got=%0b exp=0", ifa.o_last); else n_pass++;
    n_total++; if (ifc.o_frame_err !== 1'b0) $display("FAIL reset_frame_err got=%0b exp=0", ifc.o_frame_err); else n_pass++;
    n_total++; if (ifa.o_ready !== 1'b1) $display("FAIL reset_o_ready got=%0b exp=1", ifa.o_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single(input int re, input int im, input int exp_a, input int exp_b);
    logic err;
    int lat;
    logic [7:0] pa, pb;
    i_ready = 1'b1; i_real = 16'(re); i_imag = 16'(im); i_last = 1'b0; i_valid = 1'b1;
    @(negedge clk);
    n_total++; if (ifa.o_ready !== 1'b1) $display("FAIL single_o_ready got=%0b exp=1", ifa.o_ready); else n_pass++;
    push_sample(re, im, 1'b0, err);
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0; pa = '0; pb = '0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (ifa.o_valid) begin lat = n; pa = ifa.o_pixel; pb = ifb.o_pixel; end
    end
    n_total++; if (lat !== 4) $display("FAIL single_latency (%0d,%0d) got=%0d exp=4", re, im, lat); else n_pass++;
    n_total++; if (pa !== 8'(exp_a)) $display("FAIL single_pix_a (%0d,%0d) got=%0d exp=%0d", re, im, pa, exp_a); else n_pass++;
    if (exp_b >= 0) begin
      n_total++; if (pb !== 8'(exp_b)) $display("FAIL single_pix_b (%0d,%0d) got=%0d exp=%0d", re, im, pb, exp_b); else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_default();
    test_single(0, 0, 0, 0);
    test_single(1, 0, 0, 0);
    test_single(3, 0, 25, 0);
    test_single(16, 0, 64, 0);
    test_single(-32768, -32768, 248, 255);
    test_single(32767, 32767, 247, 255);
  endtask

  task automatic test_gain();
    test_single(16, 0, 64, 0);
    test_single(256, 0, 128, 128);
    test_single(-32768, -32768, 248, 255);
  endtask

  task automatic test_back_to_back();
    int sent, guard;
    logic acc, err, prev_hold;
    logic [8:0] prev_out;
    sent = 0; guard = 0; prev_hold = 1'b0; prev_out = '0;
    i_real = 16'($urandom); i_imag = 16'($urandom); i_last = 1'b0; i_valid = 1'b1;
    while (sent < 32 && guard < 2000) begin
      guard++;
      i_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_hold) begin
        n_total++;
        if (ifa.o_valid !== 1'b1 || {ifa.o_last, ifa.o_pixel} !== prev_out)
          $display("FAIL stall_hold got v=%0b data=%0h exp v=1 data=%0h", ifa.o_valid, {ifa.o_last, ifa.o_pixel}, prev_out);
        else n_pass++;
      end
      n_total++;
      if (ifa.o_ready !== (!ifa.o_valid || i_ready))
        $display("FAIL stall_o_ready got=%0b exp=%0b", ifa.o_ready, (!ifa.o_valid || i_ready));
      else n_pass++;
      prev_hold = ifa.o_valid && !i_ready;
      prev_out  = {ifa.o_last, ifa.o_pixel};
      acc = i_valid && ifa.o_ready;
      if (acc) push_sample(i_real, i_imag, 1'b0, err);
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 32) begin i_real = 16'($urandom); i_imag = 16'($urandom); end
        else i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    n_total++; if (sent !== 32) $display("FAIL b2b_sent got=%0d exp=32", sent); else n_pass++;
    i_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_total++; if (qa.size() !== 0) $display("FAIL b2b_drain_a got=%0d left exp=0", qa.size()); else n_pass++;
    n_total++; if (qb.size() !== 0) $display("FAIL b2b_drain_b got=%0d left exp=0", qb.size()); else n_pass++;
  endtask

  task automatic do_reset();
    i_valid = 1'b0; i_last = 1'b0;
    rst_n = 1'b0;
    qa.delete(); qb.delete(); qc.delete();
    cnt_c = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int n, input int last_idx);
    logic exp_err;
    for (int j = 0; j < n; j++) begin
      i_real = 16'($urandom_range(0, 4000)); i_imag = 16'($urandom_range(0, 4000));
      i_last = (j == last_idx); i_valid = 1'b1; i_ready = 1'b1;
      @(negedge clk);
      n_total++; if (ifc.o_ready !== 1'b1) $display("FAIL frame_o_ready got=%0b exp=1", ifc.o_ready); else n_pass++;
      push_sample(i_real, i_imag, i_last, exp_err);
      @(posedge clk); #1;
      n_total++;
      if (ifc.o_frame_err !== exp_err) $display("FAIL frame_err bin=%0d got=%0b exp=%0b", j, ifc.o_frame_err, exp_err);
      else n_pass++;
    end
    i_valid = 1'b0; i_last = 1'b0;
    @(posedge clk); #1;
    n_total++; if (ifc.o_frame_err !== 1'b0) $display("FAIL frame_err_pulse got=%0b exp=0", ifc.o_frame_err); else n_pass++;
  endtask

  task automatic test_frame();
    do_reset();
    send_frame(8, 7);
    send_frame(5, 4);
    send_frame(8, -1);
    repeat (6) @(posedge clk);
    #1;
    n_total++; if (qc.size() !== 0) $display("FAIL frame_drain_c got=%0d left exp=0", qc.size()); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic err;
    i_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      i_real = 16'($urandom_range(0, 4000)); i_imag = 16'($urandom_range(0, 4000));
      i_last = 1'b0; i_valid = 1'b1;
      @(negedge clk);
      push_sample(i_real, i_imag, 1'b0, err);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    n_total++; if (ifa.o_valid !== 1'b1) $display("FAIL midreset_pre_valid got=%0b exp=1", ifa.o_valid); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (ifa.o_valid !== 1'b0) $display("FAIL midreset_o_valid got=%0b exp=0", ifa.o_valid); else n_pass++;
    n_total++; if (ifc.o_valid !== 1'b0) $display("FAIL midreset_o_valid_c got=%0b exp=0", ifc.o_valid); else n_pass++;
    n_total++; if (ifa.o_pixel !== 8'd0) $display("FAIL midreset_o_pixel got=%0d exp=0", ifa.o_pixel); else n_pass++;
    qa.delete(); qb.delete(); qc.delete();
    cnt_c = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8, 7);
    repeat (6) @(posedge clk);
    #1;
    n_total++; if (qc.size() !== 0) $display("FAIL midreset_drain_c got=%0d left exp=0", qc.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_default();
    test_gain();
    test_back_to_back();
    test_frame();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
